// File: rtl/calculator3.sv
// calculator3: unsigned add/sub/mul in one cycle, restoring divide over WIDTH
// cycles, valid/ready request side and a one-cycle o_valid result pulse.
module calculator3 #(
  parameter int WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [1:0]           i_op,
  input  logic [WIDTH-1:0]     i_data1,
  input  logic [WIDTH-1:0]     i_data2,
  output logic                 o_valid,
  output logic [2*WIDTH-1:0]   o_result,
  output logic [WIDTH-1:0]     o_rem,
  output logic                 o_err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   rem_q, quo_q, dvs_q;
  logic [CW-1:0]      cnt_q;

  // One restoring step; returns {next remainder, next quotient/dividend shift}.
  // rem < dvs holds throughout, so bit WIDTH of the difference is the borrow.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                  input logic [WIDTH-1:0] quo,
                                                  input logic [WIDTH-1:0] dvs);
    logic [WIDTH:0] sh, diff;
    sh   = {rem, quo[WIDTH-1]};
    diff = sh - {1'b0, dvs};
    if (!diff[WIDTH]) return {diff[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
    else              return {sh[WIDTH-1:0],   quo[WIDTH-2:0], 1'b0};
  endfunction

  logic                 accept;
  logic [WIDTH:0]       sum_w, dif_w;
  logic [2*WIDTH-1:0]   prod_w, step_load, step_run;

  assign o_ready   = (state != DIV);
  assign accept    = i_valid & o_ready;
  assign sum_w     = {1'b0, i_data1} + {1'b0, i_data2};
  assign dif_w     = {1'b0, i_data1} - {1'b0, i_data2};
  assign prod_w    = (2*WIDTH)'(i_data1) * (2*WIDTH)'(i_data2);
  assign step_load = div_step('0, i_data1, i_data2);
  assign step_run  = div_step(rem_q, quo_q, dvs_q);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state    <= IDLE;
      o_valid  <= 1'b0;
      o_result <= '0;
      o_rem    <= '0;
      o_err    <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        DIV: begin
          rem_q <= step_run[2*WIDTH-1:WIDTH];
          quo_q <= step_run[WIDTH-1:0];
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            o_result <= {{WIDTH{1'b0}}, step_run[WIDTH-1:0]};
            o_rem    <= step_run[2*WIDTH-1:WIDTH];
            o_err    <= 1'b0;
            o_valid  <= 1'b1;
            state    <= DONE;
          end
        end
        default: begin
          if (accept) begin
            o_rem <= '0;
            o_err <= 1'b0;
            case (i_op)
              2'b00: begin
                o_result <= (2*WIDTH)'(sum_w);
                o_valid  <= 1'b1;
                state    <= DONE;
              end
              2'b01: begin
                o_result <= {{(WIDTH-1){dif_w[WIDTH]}}, dif_w};
                o_valid  <= 1'b1;
                state    <= DONE;
              end
              2'b10: begin
                o_result <= prod_w;
                o_valid  <= 1'b1;
                state    <= DONE;
              end
              default: begin
                if (i_data2 == '0) begin
                  // Quotient saturates to WIDTH ones, zero-extended like any quotient.
                  o_result <= {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                  o_rem    <= i_data1;
                  o_err    <= 1'b1;
                  o_valid  <= 1'b1;
                  state    <= DONE;
                end else begin
                  // The load edge already performs the first of the WIDTH steps.
                  rem_q    <= step_load[2*WIDTH-1:WIDTH];
                  quo_q    <= step_load[WIDTH-1:0];
                  dvs_q    <= i_data2;
                  cnt_q    <= CW'(WIDTH - 1);
                  o_result <= o_result;
                  o_rem    <= o_rem;
                  o_err    <= o_err;
                  state    <= DIV;
                end
              end
            endcase
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calculator3.sv
// Bench for calculator3: directed vector table, hand sequences for the
// multi-cycle corners, and random ops against an arithmetic reference model.
module tb_calculator3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstb;
  logic        v6, v8;
  logic [1:0]  op;
  logic [7:0]  a, b;

  logic        rdy6, vld6, err6;
  logic [11:0] res6;
  logic [5:0]  rem6;
  logic        rdy8, vld8, err8;
  logic [15:0] res8;
  logic [7:0]  rem8;

  calculator3 #(.WIDTH(6)) dut6 (
    .clk(clk), .rstb(rstb), .i_valid(v6), .o_ready(rdy6), .i_op(op),
    .i_data1(a[5:0]), .i_data2(b[5:0]), .o_valid(vld6), .o_result(res6),
    .o_rem(rem6), .o_err(err6)
  );

  calculator3 #(.WIDTH(8)) dut8 (
    .clk(clk), .rstb(rstb), .i_valid(v8), .o_ready(rdy8), .i_op(op),
    .i_data1(a), .i_data2(b), .o_valid(vld8), .o_result(res8),
    .o_rem(rem8), .o_err(err8)
  );

  int w_sel = 6;
  logic        cur_valid, cur_ready, cur_err;
  logic [15:0] cur_res;
  logic [7:0]  cur_rem;
  assign cur_valid = (w_sel == 8) ? vld8 : vld6;
  assign cur_ready = (w_sel == 8) ? rdy8 : rdy6;
  assign cur_err   = (w_sel == 8) ? err8 : err6;
  assign cur_res   = (w_sel == 8) ? res8 : {4'b0, res6};
  assign cur_rem   = (w_sel == 8) ? rem8 : {2'b0, rem6};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input bit v, input logic [1:0] o, input int x, input int y);
    op = o;
    a  = x[7:0];
    b  = y[7:0];
    v6 = v && (w_sel == 6);
    v8 = v && (w_sel == 8);
  endtask

  // Issue one request, then wait (bounded) for o_valid. lat counts negedges
  // after the accept edge; rdy_ok is cleared if o_ready rose while waiting.
  task automatic do_op(input int w, input logic [1:0] o, input int x, input int y,
                       output longint r, output longint rm, output longint e,
                       output longint lat, output bit rdy_ok);
    w_sel = w;
    @(negedge clk);
    set_req(1'b1, o, x, y);
    @(negedge clk);
    set_req(1'b0, 2'b00, 0, 0);
    lat = 1;
    rdy_ok = 1'b1;
    while (!cur_valid && lat < 64) begin
      if (cur_ready) rdy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    r  = longint'(cur_res);
    rm = longint'(cur_rem);
    e  = longint'(cur_err);
  endtask

  // Reference: plain arithmetic on the operand values.
  function automatic void model(input int w, input int o, input longint x, input longint y,
                                output longint r, output longint rm, output longint e,
                                output longint lat);
    longint mask;
    mask = (longint'(1) << (2 * w)) - 1;
    rm = 0; e = 0; lat = 1;
    case (o)
      0: r = x + y;
      1: r = (x - y) & mask;
      2: r = x * y;
      default: begin
        if (y == 0) begin
          r = (longint'(1) << w) - 1; rm = x; e = 1;
        end else begin
          r = x / y; rm = x % y; lat = w;
        end
      end
    endcase
  endfunction

  typedef struct {
    int         w;
    logic [1:0] op;
    int         a, b;
    longint     res, rem, err, lat;
  } vec_t;

  vec_t tbl[13];

  initial begin
    longint r, rm, e, lat, er, erm, ee, elat;
    bit     rdy_ok;
    int     pulses;
    longint got_res, got_rem;

    tbl[0]  = '{6, 2'd0,  4,  2,     6, 0, 0, 1};
    tbl[1]  = '{6, 2'd0, 63, 63,   126, 0, 0, 1};
    tbl[2]  = '{6, 2'd1,  5,  6, 'hFFF, 0, 0, 1};
    tbl[3]  = '{6, 2'd1,  6,  5,     1, 0, 0, 1};
    tbl[4]  = '{6, 2'd2, 63, 63, 'hF81, 0, 0, 1};
    tbl[5]  = '{6, 2'd3,  7,  2,     3, 1, 0, 6};
    tbl[6]  = '{6, 2'd3, 63,  1,    63, 0, 0, 6};
    tbl[7]  = '{6, 2'd3,  5,  9,     0, 5, 0, 6};
    tbl[8]  = '{6, 2'd3,  7,  0, 'h03F, 7, 1, 1};
    tbl[9]  = '{6, 2'd0,  1,  1,     2, 0, 0, 1};
    tbl[10] = '{8, 2'd3, 255, 16,   15, 15, 0, 8};
    tbl[11] = '{8, 2'd1,  0,  1, 'hFFFF, 0, 0, 1};
    tbl[12] = '{8, 2'd3, 200, 0,  'hFF, 200, 1, 1};

    rstb = 1'b0;
    w_sel = 6;
    set_req(1'b0, 2'b00, 0, 0);
    repeat (3) @(negedge clk);
    check("reset valid",  longint'(vld6), 0);
    check("reset result", longint'(res6), 0);
    check("reset rem",    longint'(rem6), 0);
    check("reset err",    longint'(err6), 0);
    check("reset ready",  longint'(rdy6), 1);
    rstb = 1'b1;

    foreach (tbl[i]) begin
      do_op(tbl[i].w, tbl[i].op, tbl[i].a, tbl[i].b, r, rm, e, lat, rdy_ok);
      check($sformatf("vec%0d result", i), r, tbl[i].res);
      check($sformatf("vec%0d rem", i), rm, tbl[i].rem);
      check($sformatf("vec%0d err", i), e, tbl[i].err);
      check($sformatf("vec%0d latency", i), lat, tbl[i].lat);
      if (tbl[i].op == 2'd3 && tbl[i].b != 0)
        check($sformatf("vec%0d ready low in div", i), longint'(rdy_ok), 1);
      @(negedge clk);
      check($sformatf("vec%0d single pulse", i), longint'(cur_valid), 0);
    end

    // Back-to-back adds with i_valid held.
    w_sel = 6;
    @(negedge clk);
    set_req(1'b1, 2'b00, 1, 1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("b2b%0d valid", k), longint'(cur_valid), 1);
      check($sformatf("b2b%0d result", k), longint'(cur_res), 2 * k);
      if (k < 3) set_req(1'b1, 2'b00, k + 1, k + 1);
      else       set_req(1'b0, 2'b00, 0, 0);
    end
    @(negedge clk);
    check("b2b end valid", longint'(cur_valid), 0);

    // Requests during DIV are dropped.
    @(negedge clk);
    set_req(1'b1, 2'b11, 7, 2);
    pulses = 0; got_res = -1; got_rem = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (cur_valid) begin
        pulses++; got_res = longint'(cur_res); got_rem = longint'(cur_rem);
      end
      if (k == 1) set_req(1'b1, 2'b00, 1, 1);
      if (k == 5) set_req(1'b0, 2'b00, 0, 0);
    end
    check("ignored req pulses", pulses, 1);
    check("ignored req result", got_res, 3);
    check("ignored req rem", got_rem, 1);

    // Reset mid-divide.
    @(negedge clk);
    set_req(1'b1, 2'b11, 7, 2);
    @(negedge clk);
    set_req(1'b0, 2'b00, 0, 0);
    repeat (2) @(negedge clk);
    rstb = 1'b0;
    #1;
    check("midrst valid",  longint'(vld6), 0);
    check("midrst result", longint'(res6), 0);
    check("midrst rem",    longint'(rem6), 0);
    check("midrst err",    longint'(err6), 0);
    check("midrst ready",  longint'(rdy6), 1);
    @(negedge clk);
    rstb = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (vld6) pulses++;
    end
    check("midrst no pulse", pulses, 0);
    do_op(6, 2'b00, 4, 2, r, rm, e, lat, rdy_ok);
    check("post rst result", r, 6);
    check("post rst latency", lat, 1);

    // Random ops against the reference model.
    for (int k = 0; k < 150; k++) begin
      int w, o, x, y;
      w = ($urandom_range(0, 1) == 1) ? 8 : 6;
      o = $urandom_range(0, 3);
      x = $urandom_range(0, (1 << w) - 1);
      y = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, (1 << w) - 1);
      model(w, o, longint'(x), longint'(y), er, erm, ee, elat);
      do_op(w, o[1:0], x, y, r, rm, e, lat, rdy_ok);
      check($sformatf("rnd%0d w%0d op%0d %0d,%0d result", k, w, o, x, y), r, er);
      check($sformatf("rnd%0d rem", k), rm, erm);
      check($sformatf("rnd%0d err", k), e, ee);
      check($sformatf("rnd%0d latency", k), lat, elat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
